// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  alu_pkg
//  Shared opcodes, FSM encoding and latency defaults for the ALU issue path.
//  Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;

    localparam int C_DATA_W_DEF     = 64;
    localparam int C_SIMPLE_LAT_DEF = 1;
    localparam int C_MUL_LAT_DEF    = 4;
    localparam int C_DIV_LAT_DEF    = 8;
    localparam int C_CNT_W_DEF      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ops whose results are also committed to the architectural HI/LO pair.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_lat_lookup.sv
`default_nettype none
// ============================================================================
//  alu_lat_lookup
//  Combinational map from ALU opcode to {execute latency, legal}.
//  Revision: 1.0  initial release
// ============================================================================
module alu_lat_lookup
    import alu_pkg::*;
#(
    parameter int SIMPLE_LAT = C_SIMPLE_LAT_DEF,
    parameter int MUL_LAT    = C_MUL_LAT_DEF,
    parameter int DIV_LAT    = C_DIV_LAT_DEF,
    parameter int CNT_W      = C_CNT_W_DEF
) (
    input  logic [3:0]       i_op,
    output logic [CNT_W-1:0] o_lat,
    output logic             o_legal
);

    always_comb begin
        o_lat   = '0;
        o_legal = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_lat   = CNT_W'(SIMPLE_LAT);
                o_legal = 1'b1;
            end
            OP_MUL: begin
                o_lat   = CNT_W'(MUL_LAT);
                o_legal = 1'b1;
            end
            OP_DIV: begin
                o_lat   = CNT_W'(DIV_LAT);
                o_legal = 1'b1;
            end
            default: begin
                o_lat   = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  alu_issue_ctrl
//  Issues operands/opcode to the ALU, holds them for the per-op latency,
//  captures the result and maintains HI/LO. Optional: ALU_ISSUE_B2B_EN.
//  Revision: 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W_DEF,
    parameter int SIMPLE_LAT = C_SIMPLE_LAT_DEF,
    parameter int MUL_LAT    = C_MUL_LAT_DEF,
    parameter int DIV_LAT    = C_DIV_LAT_DEF,
    parameter int CNT_W      = C_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [4:0]        req_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [DATA_W-1:0] hi_reg,
    output logic [DATA_W-1:0] lo_reg
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_lat;
    logic             w_legal;
    logic             w_accept;
    logic             w_err;

    alu_lat_lookup #(
        .SIMPLE_LAT (SIMPLE_LAT),
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .CNT_W      (CNT_W)
    ) u_lat_lookup (
        .i_op    (req_op),
        .o_lat   (w_lat),
        .o_legal (w_legal)
    );

`ifdef ALU_ISSUE_B2B_EN
    // Retiring a response frees the slot in the same cycle.
    assign req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
`else
    assign req_ready = (r_state == ST_IDLE);
`endif

    assign w_accept = req_valid && req_ready;
    assign w_err    = !w_legal || ((req_op == OP_DIV) && (req_b == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_rd     <= '0;
            rsp_err    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_valid  <= 1'b1;
                        r_state    <= ST_RESP;
                        if (is_hilo_op(alu_opcode)) begin
                            lo_reg <= alu_result;
                            hi_reg <= alu_hi;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // An accept overrides the RESP retirement above when both happen together.
            if (w_accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_opcode <= req_op;
                rsp_rd     <= req_rd;
                if (w_err) begin
                    r_state    <= ST_RESP;
                    r_cnt      <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b1;
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                end else begin
                    r_state   <= ST_EXEC;
                    r_cnt     <= w_lat;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_alu_issue_ctrl
//  Directed plus randomized checks of alu_issue_ctrl against a reference model.
//  Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam logic [3:0] T_ADD = 4'b0010;
    localparam logic [3:0] T_SUB = 4'b0110;
    localparam logic [3:0] T_MUL = 4'b1000;
    localparam logic [3:0] T_DIV = 4'b0011;
    localparam logic [3:0] T_AND = 4'b0000;
    localparam logic [3:0] T_OR  = 4'b0001;
    localparam int T_SIMPLE_LAT = 1;
    localparam int T_MUL_LAT    = 4;
    localparam int T_DIV_LAT    = 8;
`ifdef ALU_ISSUE_B2B_EN
    localparam int T_B2B_GAP = 2;
`else
    localparam int T_B2B_GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [4:0]  req_rd;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [63:0] alu_result;
    logic [63:0] alu_hi;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_zero;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic [63:0] hi_reg;
    logic [63:0] lo_reg;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] m_hi    = '0;
    logic [63:0] m_lo    = '0;
    logic [127:0] alu_prod;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_hi     (alu_hi),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .hi_reg     (hi_reg),
        .lo_reg     (lo_reg)
    );

    // Behavioural ALU: full 128-bit product for mul, quotient/remainder for div.
    always_comb begin
        alu_prod   = '0;
        alu_result = '0;
        alu_hi     = '0;
        case (alu_opcode)
            T_ADD: alu_result = alu_a + alu_b;
            T_SUB: alu_result = alu_a - alu_b;
            T_AND: alu_result = alu_a & alu_b;
            T_OR:  alu_result = alu_a | alu_b;
            T_MUL: begin
                alu_prod   = {64'd0, alu_a} * {64'd0, alu_b};
                alu_result = alu_prod[63:0];
                alu_hi     = alu_prod[127:64];
            end
            T_DIV: begin
                if (alu_b != '0) begin
                    alu_result = alu_a / alu_b;
                    alu_hi     = alu_a % alu_b;
                end
            end
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: expected response, latency and HI/LO update for one request.
    task automatic predict(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           output int lat, output logic err, output logic [63:0] res,
                           output logic z);
        logic [127:0] p;
        err = 1'b0;
        res = '0;
        lat = 0;
        case (op)
            T_ADD: begin res = a + b; lat = T_SIMPLE_LAT; end
            T_SUB: begin res = a - b; lat = T_SIMPLE_LAT; end
            T_AND: begin res = a & b; lat = T_SIMPLE_LAT; end
            T_OR:  begin res = a | b; lat = T_SIMPLE_LAT; end
            T_MUL: begin
                p    = {64'd0, a} * {64'd0, b};
                res  = p[63:0];
                m_lo = p[63:0];
                m_hi = p[127:64];
                lat  = T_MUL_LAT;
            end
            T_DIV: begin
                if (b == 64'd0) begin
                    err = 1'b1;
                end else begin
                    res  = a / b;
                    m_lo = a / b;
                    m_hi = a % b;
                    lat  = T_DIV_LAT;
                end
            end
            default: err = 1'b1;
        endcase
        z = !err && (res == 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        int          lat;
        int          n;
        logic        err;
        logic        z;
        logic [63:0] res;
        predict(op, a, b, lat, err, res, z);
        @(posedge clk); #1;
        check("ready_idle", 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        check("alu_opcode", 128'(alu_opcode), 128'(op));
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(lat + 1));
        check("rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check("rsp_err", 128'(rsp_err), 128'(err));
        check("rsp_result", 128'(rsp_result), 128'(res));
        check("rsp_zero", 128'(rsp_zero), 128'(z));
        check("rsp_rd", 128'(rsp_rd), 128'(rd));
        check("alu_a_hold", 128'(alu_a), 128'(a));
        check("alu_b_hold", 128'(alu_b), 128'(b));
        check("hi_reg", 128'(hi_reg), 128'(m_hi));
        check("lo_reg", 128'(lo_reg), 128'(m_lo));
        @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, 128'(alu_a), 128'(0));
        check({tag, "_alu_b"}, 128'(alu_b), 128'(0));
        check({tag, "_alu_op"}, 128'(alu_opcode), 128'(0));
        check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({tag, "_rsp_result"}, 128'(rsp_result), 128'(0));
        check({tag, "_rsp_zero"}, 128'(rsp_zero), 128'(0));
        check({tag, "_rsp_rd"}, 128'(rsp_rd), 128'(0));
        check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        check({tag, "_hi"}, 128'(hi_reg), 128'(0));
        check({tag, "_lo"}, 128'(lo_reg), 128'(0));
        check({tag, "_ready"}, 128'(req_ready), 128'(1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [7];
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          t1;
        int          t2;
        logic        go;

        ops = '{T_ADD, T_SUB, T_MUL, T_DIV, T_AND, T_OR, 4'b1111};
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_rd    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        run_op(T_ADD, 64'd5, 64'd7, 5'd3);
        run_op(T_SUB, 64'd9, 64'd9, 5'd4);
        run_op(T_OR, 64'hF0, 64'h0F, 5'd5);
        run_op(T_MUL, 64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000, 5'd6);
        check("mul_hi_const", 128'(hi_reg), 128'(64'h10000));
        run_op(T_DIV, 64'd100, 64'd7, 5'd7);
        check("div_lo_const", 128'(lo_reg), 128'(64'd14));
        check("div_hi_const", 128'(hi_reg), 128'(64'd2));
        run_op(T_DIV, 64'd50, 64'd0, 5'd8);
        run_op(4'b1111, 64'd1, 64'd2, 5'd9);

        // Response held off by writeback: everything stays put.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 4'b1111;
        req_rd    = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 128'(rsp_valid), 128'(1'b1));
            check("hold_err", 128'(rsp_err), 128'(1'b1));
            check("hold_rd", 128'(rsp_rd), 128'(5'd17));
            check("hold_result", 128'(rsp_result), 128'(0));
            check("hold_ready", 128'(req_ready), 128'(1'b0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);

        // Two adds offered continuously.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = T_ADD;
        req_a     = 64'd1;
        req_b     = 64'd2;
        req_rd    = 5'd1;
        @(posedge clk); #1;
        req_a  = 64'd10;
        req_b  = 64'd20;
        req_rd = 5'd2;
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_rd == 5'd1 && t1 < 0) begin
                t1 = i;
                check("b2b_first_res", 128'(rsp_result), 128'(64'd3));
            end
            if (rsp_valid && rsp_rd == 5'd2 && t2 < 0) begin
                t2 = i;
                check("b2b_second_res", 128'(rsp_result), 128'(64'd30));
            end
            go = req_valid && req_ready;
            @(posedge clk); #1;
            if (go) req_valid = 1'b0;
        end
        check("b2b_first_lat", 128'(t1), 128'(2));
        check("b2b_gap", 128'(t2 - t1), 128'(T_B2B_GAP));
        @(posedge clk);

        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (op == T_DIV) begin
                if ($urandom_range(0, 3) == 0) b = 64'd0;
                else if ($urandom_range(0, 1) == 0) b = 64'($urandom_range(1, 1000));
            end
            if (op == T_SUB && $urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, 5'($urandom_range(0, 31)));
        end

        // Reset lands while a mul is in EXEC.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = T_MUL;
        req_a     = 64'd3;
        req_b     = 64'd5;
        req_rd    = 5'd21;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check_all_zero("midreset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset_no_rsp", 128'(rsp_valid), 128'(1'b0));
        end
        check("midreset_hi", 128'(hi_reg), 128'(0));
        check("midreset_lo", 128'(lo_reg), 128'(0));

        run_op(T_AND, 64'hFF00, 64'h0FF0, 5'd30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
